// File: rtl/datapath_pkg.sv
// Shared control-word and forwarding types for the hazard-aware MIPS pipeline.
package datapath_pkg;
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t       CTRL_NOP  = '0;
  localparam logic [31:0] INSTR_NOP = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;
endpackage

// File: rtl/hazard_unit.sv
// Combinational stall / flush / forward-select logic for the 5-stage pipeline.
// HAZARD_DATAPATH_FWD_EN selects forwarding; otherwise RAW hazards stall in D.
module hazard_unit
  import datapath_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs_D,
  input  logic [REG_AW-1:0] i_rt_D,
  input  logic [REG_AW-1:0] i_rs_E,
  input  logic [REG_AW-1:0] i_rt_E,
  input  logic [REG_AW-1:0] i_writereg_E,
  input  logic [REG_AW-1:0] i_writereg_M,
  input  logic [REG_AW-1:0] i_writereg_WB,
  input  logic              i_regwrite_E,
  input  logic              i_memtoreg_E,
  input  logic              i_regwrite_M,
  input  logic              i_regwrite_WB,
  input  logic              i_branch_M,
  input  logic              i_zero_M,
  output logic              o_stall,
  output logic              o_flush,
  output fwd_sel_e          o_fwd_a,
  output fwd_sel_e          o_fwd_b
);
  logic w_taken;
  logic w_hazard;

  assign w_taken = i_branch_M & i_zero_M;

`ifdef HAZARD_DATAPATH_FWD_EN
  // M is younger than WB, so its result takes priority.
  function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] src,
                                        input logic [REG_AW-1:0] wr_m, input logic we_m,
                                        input logic [REG_AW-1:0] wr_wb, input logic we_wb);
    fwd_sel_e sel;
    sel = FWD_REG;
    if (src != '0) begin
      if (we_m && (wr_m == src))        sel = FWD_M;
      else if (we_wb && (wr_wb == src)) sel = FWD_WB;
    end
    return sel;
  endfunction

  assign w_hazard = i_memtoreg_E & i_regwrite_E & (i_writereg_E != '0) &
                    ((i_rs_D == i_writereg_E) | (i_rt_D == i_writereg_E));
  assign o_fwd_a  = fwd_pick(i_rs_E, i_writereg_M, i_regwrite_M, i_writereg_WB, i_regwrite_WB);
  assign o_fwd_b  = fwd_pick(i_rt_E, i_writereg_M, i_regwrite_M, i_writereg_WB, i_regwrite_WB);
`else
  function automatic logic src_hit(input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] wr, input logic we);
    return (src != '0) && we && (src == wr);
  endfunction

  logic w_unused;

  assign w_hazard = src_hit(i_rs_D, i_writereg_E, i_regwrite_E) |
                    src_hit(i_rt_D, i_writereg_E, i_regwrite_E) |
                    src_hit(i_rs_D, i_writereg_M, i_regwrite_M) |
                    src_hit(i_rt_D, i_writereg_M, i_regwrite_M);
  assign o_fwd_a  = FWD_REG;
  assign o_fwd_b  = FWD_REG;
  assign w_unused = ^{i_rs_E, i_rt_E, i_writereg_WB, i_regwrite_WB, i_memtoreg_E};
`endif

  // A taken branch squashes the stalled instruction anyway, so it wins.
  assign o_flush = w_taken;
  assign o_stall = w_hazard & ~w_taken;
endmodule

// File: rtl/hazard_datapath.sv
// 5-stage MIPS integer datapath (F/D/E/M/WB) with load-use stall, branch flush in M and WB->D bypass.
// Define HAZARD_DATAPATH_FWD_EN to enable E-stage operand forwarding.
module hazard_datapath
  import datapath_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              REG_AW   = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            REGWRITE_D,
  input  logic            MEMTOREG_D,
  input  logic            MEMWRITE_D,
  input  logic            BRANCH_D,
  input  logic            ALUSRC_D,
  input  logic            REGDST_D,
  input  logic [2:0]      ALUCONTROL_D,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] readdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr_D_control,
  output logic [XLEN-1:0] aluresult,
  output logic [XLEN-1:0] writedata,
  output logic            memwrite,
  output logic            stall,
  output logic            flush
);
  localparam int NREG = 2 ** REG_AW;

  ctrl_t             w_ctrl_D, r_ctrl_E, r_ctrl_M, r_ctrl_WB;
  logic [XLEN-1:0]   r_pc, w_pcplus4_F, w_pcnext;
  logic [XLEN-1:0]   r_instr_D, r_pcplus4_D, w_signimm_D, w_rd1_D, w_rd2_D;
  logic [REG_AW-1:0] w_rs_D, w_rt_D, w_rd_D;
  logic [XLEN-1:0]   r_rf [NREG];
  logic [XLEN-1:0]   r_rd1_E, r_rd2_E, r_signimm_E, r_pcplus4_E;
  logic [REG_AW-1:0] r_rs_E, r_rt_E, r_rd_E, w_writereg_E;
  logic [XLEN-1:0]   w_srca_E, w_srcb_E, w_writedata_E, w_aluresult_E, w_pcbranch_E;
  logic              w_zero_E;
  fwd_sel_e          w_fwd_a, w_fwd_b;
  logic [XLEN-1:0]   r_aluresult_M, r_writedata_M, r_pcbranch_M;
  logic [REG_AW-1:0] r_writereg_M;
  logic              r_zero_M;
  logic [XLEN-1:0]   r_aluout_WB, r_readdata_WB, w_result_WB;
  logic [REG_AW-1:0] r_writereg_WB;
  logic              w_stall, w_flush, w_unused;

  function automatic logic [XLEN-1:0] alu_op(input logic signed [XLEN-1:0] a,
                                             input logic signed [XLEN-1:0] b,
                                             input logic [2:0] op);
    logic [XLEN-1:0] y;
    case (op)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = a + b;
      3'b110:  y = a - b;
      3'b111:  y = XLEN'(a < b);
      default: y = '0;
    endcase
    return y;
  endfunction

  function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_e sel, input logic [XLEN-1:0] reg_v,
                                              input logic [XLEN-1:0] m_v, input logic [XLEN-1:0] wb_v);
    logic [XLEN-1:0] y;
    case (sel)
      FWD_M:   y = m_v;
      FWD_WB:  y = wb_v;
      default: y = reg_v;
    endcase
    return y;
  endfunction

  // ---- F stage ----
  assign w_pcplus4_F = r_pc + XLEN'(4);
  assign w_pcnext    = w_flush ? r_pcbranch_M : w_pcplus4_F;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_pc <= RESET_PC;
    else if (!w_stall) r_pc <= w_pcnext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_D   <= '0;
      r_pcplus4_D <= '0;
    end else if (w_flush) begin
      r_instr_D   <= XLEN'(INSTR_NOP);
      r_pcplus4_D <= '0;
    end else if (!w_stall) begin
      r_instr_D   <= instr;
      r_pcplus4_D <= w_pcplus4_F;
    end
  end

  // ---- D stage ----
  assign w_ctrl_D    = '{REGWRITE_D, MEMTOREG_D, MEMWRITE_D, BRANCH_D, ALUSRC_D, REGDST_D, ALUCONTROL_D};
  assign w_rs_D      = REG_AW'(r_instr_D[25:21]);
  assign w_rt_D      = REG_AW'(r_instr_D[20:16]);
  assign w_rd_D      = REG_AW'(r_instr_D[15:11]);
  assign w_signimm_D = {{(XLEN-16){r_instr_D[15]}}, r_instr_D[15:0]};

  always_comb begin
    w_rd1_D = r_rf[w_rs_D];
    w_rd2_D = r_rf[w_rt_D];
    if (r_ctrl_WB.regwrite && (r_writereg_WB != '0)) begin
      if (r_writereg_WB == w_rs_D) w_rd1_D = w_result_WB;
      if (r_writereg_WB == w_rt_D) w_rd2_D = w_result_WB;
    end
    if (w_rs_D == '0) w_rd1_D = '0;
    if (w_rt_D == '0) w_rd2_D = '0;
  end

  always_ff @(posedge clk) begin
    if (r_ctrl_WB.regwrite && (r_writereg_WB != '0)) r_rf[r_writereg_WB] <= w_result_WB;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || w_stall || w_flush) begin
      r_ctrl_E    <= CTRL_NOP;
      r_rd1_E     <= '0;
      r_rd2_E     <= '0;
      r_signimm_E <= '0;
      r_pcplus4_E <= '0;
      r_rs_E      <= '0;
      r_rt_E      <= '0;
      r_rd_E      <= '0;
    end else begin
      r_ctrl_E    <= w_ctrl_D;
      r_rd1_E     <= w_rd1_D;
      r_rd2_E     <= w_rd2_D;
      r_signimm_E <= w_signimm_D;
      r_pcplus4_E <= r_pcplus4_D;
      r_rs_E      <= w_rs_D;
      r_rt_E      <= w_rt_D;
      r_rd_E      <= w_rd_D;
    end
  end

  // ---- E stage ----
  assign w_writereg_E  = r_ctrl_E.regdst ? r_rd_E : r_rt_E;
  assign w_srca_E      = fwd_mux(w_fwd_a, r_rd1_E, r_aluresult_M, w_result_WB);
  assign w_writedata_E = fwd_mux(w_fwd_b, r_rd2_E, r_aluresult_M, w_result_WB);
  assign w_srcb_E      = r_ctrl_E.alusrc ? r_signimm_E : w_writedata_E;
  assign w_aluresult_E = alu_op(w_srca_E, w_srcb_E, r_ctrl_E.alucontrol);
  assign w_zero_E      = (w_aluresult_E == '0);
  assign w_pcbranch_E  = r_pcplus4_E + (r_signimm_E << 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset || w_flush) begin
      r_ctrl_M      <= CTRL_NOP;
      r_aluresult_M <= '0;
      r_writedata_M <= '0;
      r_pcbranch_M  <= '0;
      r_writereg_M  <= '0;
      r_zero_M      <= 1'b0;
    end else begin
      r_ctrl_M      <= r_ctrl_E;
      r_aluresult_M <= w_aluresult_E;
      r_writedata_M <= w_writedata_E;
      r_pcbranch_M  <= w_pcbranch_E;
      r_writereg_M  <= w_writereg_E;
      r_zero_M      <= w_zero_E;
    end
  end

  // ---- M stage ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl_WB     <= CTRL_NOP;
      r_aluout_WB   <= '0;
      r_readdata_WB <= '0;
      r_writereg_WB <= '0;
    end else begin
      r_ctrl_WB     <= r_ctrl_M;
      r_aluout_WB   <= r_aluresult_M;
      r_readdata_WB <= readdata;
      r_writereg_WB <= r_writereg_M;
    end
  end

  // ---- WB stage ----
  assign w_result_WB = r_ctrl_WB.memtoreg ? r_readdata_WB : r_aluout_WB;

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .i_rs_D        (w_rs_D),
    .i_rt_D        (w_rt_D),
    .i_rs_E        (r_rs_E),
    .i_rt_E        (r_rt_E),
    .i_writereg_E  (w_writereg_E),
    .i_writereg_M  (r_writereg_M),
    .i_writereg_WB (r_writereg_WB),
    .i_regwrite_E  (r_ctrl_E.regwrite),
    .i_memtoreg_E  (r_ctrl_E.memtoreg),
    .i_regwrite_M  (r_ctrl_M.regwrite),
    .i_regwrite_WB (r_ctrl_WB.regwrite),
    .i_branch_M    (r_ctrl_M.branch),
    .i_zero_M      (r_zero_M),
    .o_stall       (w_stall),
    .o_flush       (w_flush),
    .o_fwd_a       (w_fwd_a),
    .o_fwd_b       (w_fwd_b)
  );

  assign pc              = r_pc;
  assign instr_D_control = r_instr_D;
  assign aluresult       = r_aluresult_M;
  assign writedata       = r_writedata_M;
  assign memwrite        = r_ctrl_M.memwrite;
  assign stall           = w_stall;
  assign flush           = w_flush;

  // Control bits that have no consumer in the later stages.
  assign w_unused = ^{r_ctrl_M.alusrc, r_ctrl_M.regdst, r_ctrl_M.alucontrol,
                      r_ctrl_WB.memwrite, r_ctrl_WB.branch, r_ctrl_WB.alusrc,
                      r_ctrl_WB.regdst, r_ctrl_WB.alucontrol};
endmodule

// File: tb/tb_hazard_datapath.sv
// Scoreboard bench for hazard_datapath: short MIPS programs, stores compared against expected queue.
// Stall-count expectations follow the HAZARD_DATAPATH_FWD_EN setting of the build.
module tb_hazard_datapath;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_d, memtoreg_d, memwrite_d, branch_d, alusrc_d, regdst_d;
  logic [2:0]  alucontrol_d;
  logic [31:0] instr, readdata, pc, instr_d, aluresult, writedata;
  logic        memwrite, stall, flush;
  logic [5:0]  op, funct;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  st_t         sb_q [$];

  int          n_checks, n_errors;
  int          stall_cnt, flush_cnt, run_len, max_run;
  logic        prev_flush;
  logic [31:0] exp_target;

`ifdef HAZARD_DATAPATH_FWD_EN
  localparam int P1_STALL = 0, P2_STALL = 1, P2_RUN = 1, P4_STALL = 0;
`else
  localparam int P1_STALL = 5, P2_STALL = 4, P2_RUN = 2, P4_STALL = 2;
`endif

  always #5 clk = ~clk;

  hazard_datapath #(.XLEN(32), .REG_AW(5), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .REGWRITE_D      (regwrite_d),
    .MEMTOREG_D      (memtoreg_d),
    .MEMWRITE_D      (memwrite_d),
    .BRANCH_D        (branch_d),
    .ALUSRC_D        (alusrc_d),
    .REGDST_D        (regdst_d),
    .ALUCONTROL_D    (alucontrol_d),
    .instr           (instr),
    .readdata        (readdata),
    .pc              (pc),
    .instr_D_control (instr_d),
    .aluresult       (aluresult),
    .writedata       (writedata),
    .memwrite        (memwrite),
    .stall           (stall),
    .flush           (flush)
  );

  assign instr    = imem[pc[9:2]];
  assign readdata = dmem[aluresult[9:2]];
  always @(posedge clk) if (memwrite) dmem[aluresult[9:2]] <= writedata;

  // Decode-stage control unit model
  always_comb begin
    op           = instr_d[31:26];
    funct        = instr_d[5:0];
    regwrite_d   = 1'b0;
    memtoreg_d   = 1'b0;
    memwrite_d   = 1'b0;
    branch_d     = 1'b0;
    alusrc_d     = 1'b0;
    regdst_d     = 1'b0;
    alucontrol_d = 3'b000;
    if (instr_d != 32'h0) begin
      case (op)
        6'h00: begin
          regwrite_d = 1'b1;
          regdst_d   = 1'b1;
          case (funct)
            6'h22:   alucontrol_d = 3'b110;
            6'h24:   alucontrol_d = 3'b000;
            6'h25:   alucontrol_d = 3'b001;
            6'h2a:   alucontrol_d = 3'b111;
            default: alucontrol_d = 3'b010;
          endcase
        end
        6'h23: begin regwrite_d = 1'b1; memtoreg_d = 1'b1; alusrc_d = 1'b1; alucontrol_d = 3'b010; end
        6'h2b: begin memwrite_d = 1'b1; alusrc_d = 1'b1; alucontrol_d = 3'b010; end
        6'h04: begin branch_d = 1'b1; alucontrol_d = 3'b110; end
        6'h08: begin regwrite_d = 1'b1; alusrc_d = 1'b1; alucontrol_d = 3'b010; end
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input int rt, input int rs, input int imm);
    return {opc, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] addr, input logic [31:0] data);
    st_t e;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic cycle_mon();
    @(negedge clk);
    if (prev_flush) check("pc_target", pc, exp_target);
    prev_flush = flush;
    if (stall) begin
      stall_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (flush) flush_cnt++;
    if (memwrite) begin
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        st_t e;
        e = sb_q.pop_front();
        check("st_addr", aluresult, e.addr);
        check("st_data", writedata, e.data);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    stall_cnt  = 0;
    flush_cnt  = 0;
    run_len    = 0;
    max_run    = 0;
    prev_flush = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic end_prog(input int exp_stall, input int exp_flush);
    check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic load_clear();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  task automatic load_p1();
    load_clear();
    imem[0] = enc_i(6'h08, 2, 0, 5);
    imem[1] = enc_i(6'h08, 3, 0, 7);
    imem[2] = enc_i(6'h08, 5, 0, 2);
    imem[3] = enc_r(6'h20, 1, 2, 3);
    imem[4] = enc_r(6'h22, 4, 1, 5);
    imem[5] = enc_i(6'h2b, 4, 0, 32'h40);
    imem[6] = enc_i(6'h2b, 1, 0, 32'h44);
    sb_push(32'h40, 32'd10);
    sb_push(32'h44, 32'd12);
  endtask

  initial begin
    logic seen;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    prev_flush = 1'b0;
    exp_target = 32'h0;
    load_clear();
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    dmem[0] = 32'd9;

    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_memwrite", 32'(memwrite), 32'd0);
    check("rst_aluresult", aluresult, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_instr_d", instr_d, 32'h0);

    // add/sub dependency chain
    load_p1();
    do_reset();
    repeat (30) cycle_mon();
    end_prog(P1_STALL, 0);

    // load-use
    load_clear();
    imem[0] = enc_i(6'h23, 1, 0, 0);
    imem[1] = enc_r(6'h20, 2, 1, 1);
    imem[2] = enc_i(6'h2b, 2, 0, 32'h48);
    sb_push(32'h48, 32'd18);
    do_reset();
    repeat (30) cycle_mon();
    check("lw_stall_run", 32'(max_run), 32'(P2_RUN));
    end_prog(P2_STALL, 0);

    // taken branch over three writes of $7
    load_clear();
    imem[0] = enc_i(6'h08, 7, 0, 42);
    imem[3] = enc_i(6'h04, 0, 0, 3);
    imem[4] = enc_i(6'h08, 7, 0, 1);
    imem[5] = enc_i(6'h08, 7, 0, 2);
    imem[6] = enc_i(6'h08, 7, 0, 3);
    imem[7] = enc_i(6'h2b, 7, 0, 32'h50);
    sb_push(32'h50, 32'd42);
    exp_target = 32'd28;
    do_reset();
    repeat (30) cycle_mon();
    end_prog(0, 1);

    // register 0 is never forwarded
    load_clear();
    imem[0] = enc_i(6'h08, 3, 0, 77);
    imem[3] = enc_i(6'h08, 0, 0, 5);
    imem[4] = enc_r(6'h20, 3, 0, 0);
    imem[5] = enc_i(6'h2b, 3, 0, 32'h58);
    sb_push(32'h58, 32'd0);
    do_reset();
    repeat (30) cycle_mon();
    end_prog(P4_STALL, 0);

    // reset while a store sits in M, then rerun
    load_p1();
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle_mon();
      if (memwrite) seen = 1'b1;
    end
    check("mid_store_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_memwrite", 32'(memwrite), 32'd0);
    check("mid_pc", pc, 32'h0);
    check("mid_aluresult", aluresult, 32'h0);
    check("mid_writedata", writedata, 32'h0);
    check("mid_stall", 32'(stall), 32'd0);
    check("mid_flush", 32'(flush), 32'd0);
    sb_q.delete();
    load_p1();
    do_reset();
    repeat (30) cycle_mon();
    end_prog(P1_STALL, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
